// File: rtl/button_debounce.sv
// button_debounce: per-channel 2-flop synchronizer plus STABLE/SETTLE qualifier that accepts a level after STABLE_CYCLES consecutive samples
module button_debounce #(
   parameter int   WIDTH         = 2,
   parameter int   STABLE_CYCLES = 1000000,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] btn_out,
   output logic [WIDTH-1:0] busy
);
   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
   typedef enum logic {STABLE, SETTLE} state_t;
   logic [WIDTH-1:0] meta_q, sync_q, out_q, out_d;
   state_t           state_q [WIDTH];
   state_t           state_d [WIDTH];
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= {WIDTH{INIT_LEVEL}};
         sync_q <= {WIDTH{INIT_LEVEL}};
         out_q  <= {WIDTH{INIT_LEVEL}};
         for (int c = 0; c < WIDTH; c++) begin
            state_q[c] <= STABLE;
            cnt_q[c]   <= '0;
         end
      end else begin
         meta_q <= btn_in;
         sync_q <= meta_q;
         out_q  <= out_d;
         for (int c = 0; c < WIDTH; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
         end
      end
   end
   always_comb begin
      out_d = out_q;
      for (int c = 0; c < WIDTH; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         if (state_q[c] == STABLE) begin
            state_d[c] = (sync_q[c] != out_q[c]) ? SETTLE : STABLE;
            cnt_d[c]   = (sync_q[c] != out_q[c]) ? CW'(1) : '0;
         end else if (sync_q[c] == out_q[c]) begin
            state_d[c] = STABLE;
            cnt_d[c]   = '0;
         end else if (cnt_q[c] == LAST) begin
            out_d[c]   = sync_q[c];
            state_d[c] = STABLE;
            cnt_d[c]   = '0;
         end else begin
            cnt_d[c]   = cnt_q[c] + CW'(1);
         end
      end
   end
   always_comb begin
      busy = '0;
      for (int c = 0; c < WIDTH; c++) busy[c] = (state_q[c] == SETTLE);
   end
   assign btn_out = out_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: random and directed stimulus checked against a run-length reference model of the debouncer
module tb_button_debounce;
   localparam int   W    = 2;
   localparam int   N    = 8;
   localparam logic INIT = 1'b0;
   logic         clk, rst;
   logic [W-1:0] btn_in, btn_out, busy;
   logic [W-1:0] m_s1, m_sync, m_out, m_busy;
   int           run [W];
   int           n_chk, n_fail, bcnt;
   int           hold [W];

   button_debounce #(.WIDTH(W), .STABLE_CYCLES(N), .INIT_LEVEL(INIT)) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_out(btn_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a level is accepted once N consecutive synchronized samples disagree with the output
   always @(posedge clk) begin
      if (rst) begin
         m_s1   = {W{INIT}};
         m_sync = {W{INIT}};
         m_out  = {W{INIT}};
         m_busy = '0;
         for (int c = 0; c < W; c++) run[c] = 0;
      end else begin
         for (int c = 0; c < W; c++) begin
            if (m_sync[c] != m_out[c]) begin
               run[c]++;
               if (run[c] == N) begin
                  m_out[c] = m_sync[c];
                  run[c]   = 0;
               end
            end else begin
               run[c] = 0;
            end
            m_busy[c] = (run[c] != 0);
         end
         m_sync = m_s1;
         m_s1   = btn_in;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
      chk("model_btn_out", 32'(btn_out), 32'(m_out));
      chk("model_busy", 32'(busy), 32'(m_busy));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      m_s1   = '0;
      m_sync = '0;
      m_out  = '0;
      m_busy = '0;
      for (int c = 0; c < W; c++) begin
         run[c]  = 0;
         hold[c] = 0;
      end
      rst    = 1'b1;
      btn_in = '0;
      idle(2);
      chk("reset_btn_out", 32'(btn_out), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      idle(5);
      chk("idle_busy", 32'(busy), 32'd0);
      // clean step on ch0
      btn_in = 2'b01;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("step_busy0", 32'(busy[0]), 32'(k >= 3 && k < 10));
         chk("step_out0", 32'(btn_out[0]), 32'(k >= 10));
         chk("step_out1", 32'(btn_out[1]), 32'd0);
      end
      // release
      btn_in = 2'b00;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("release_out0", 32'(btn_out[0]), 32'(k < 10));
      end
      // bounce: high 5, low 1, high held
      for (int k = 1; k <= 20; k++) begin
         btn_in[0] = (k != 6);
         cyc();
         chk("bounce_out0", 32'(btn_out[0]), 32'(k >= 16));
      end
      btn_in = 2'b00;
      idle(12);
      // short glitches
      bcnt = 0;
      btn_in[0] = 1'b1;
      cyc();
      if (busy[0]) bcnt++;
      btn_in[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (busy[0]) bcnt++;
         chk("glitch1_out0", 32'(btn_out[0]), 32'd0);
      end
      chk("glitch1_busy_len", 32'(bcnt), 32'd1);
      bcnt = 0;
      btn_in[0] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         cyc();
         if (busy[0]) bcnt++;
      end
      btn_in[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (busy[0]) bcnt++;
         chk("glitch7_out0", 32'(btn_out[0]), 32'd0);
      end
      chk("glitch7_busy_len", 32'(bcnt), 32'd7);
      // both channels together
      btn_in = 2'b11;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("both_out", 32'(btn_out), (k >= 10) ? 32'd3 : 32'd0);
      end
      btn_in = 2'b00;
      idle(12);
      // reset mid-qualification
      btn_in = 2'b11;
      idle(6);
      chk("pre_rst_busy", 32'(busy), 32'd3);
      rst = 1'b1;
      cyc();
      chk("rst_mid_out", 32'(btn_out), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("requal_out", 32'(btn_out), (k >= 10) ? 32'd3 : 32'd0);
         chk("requal_busy", 32'(busy), (k >= 3 && k < 10) ? 32'd3 : 32'd0);
      end
      btn_in = 2'b00;
      idle(12);
      // randomized bursts with occasional reset
      for (int t = 0; t < 4000; t++) begin
         for (int c = 0; c < W; c++) begin
            if (hold[c] == 0) begin
               btn_in[c] = 1'($urandom_range(0, 1));
               hold[c]   = $urandom_range(1, 13);
            end
            hold[c]--;
         end
         rst = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0;
      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of independent button channels.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1000000: consecutive synchronized samples needed to accept a new level (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-003 SHALL have parameter INIT_LEVEL, default 1'b0: level of all channels after reset.
REQ-004 SHALL have port clk  input  1: 100 MHz system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: one clock; reset is synchronous and active-high.
REQ-006 SHALL have port btn_in  input  WIDTH: raw asynchronous button pins (BUT).
REQ-007 SHALL have port btn_out  output  WIDTH: debounced, glitch-free level per channel; feeds button_ed / edge_detect.
REQ-008 SHALL have port busy  output  WIDTH: per channel, high while a candidate level change is being qualified.

Function
REQ-009 SHALL pass each btn_in bit through a private 2-flop synchronizer; only the second flop output (sync) is used downstream; the first flop SHALL NOT drive any logic except the second flop.
REQ-010 SHALL give each channel its own counter, ceil(log2(STABLE_CYCLES)) bits wide, and its own 2-state FSM: STABLE, SETTLE.
REQ-011 STABLE: busy=0, counter=0; if sync != btn_out, go to SETTLE with counter=1; else stay.
REQ-012 SETTLE: busy=1; if sync == btn_out (bounce), return to STABLE, counter=0, btn_out unchanged.
REQ-013 SETTLE: if sync != btn_out and counter == STABLE_CYCLES-1, set btn_out <= sync, return to STABLE, counter=0.
REQ-014 SETTLE: otherwise increment counter by 1; the counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-015 Latency: btn_out SHALL change exactly on the clock edge after STABLE_CYCLES consecutive sync samples differ from btn_out; pin-to-output is 2+STABLE_CYCLES cycles for a clean step.
REQ-016 A single-sample bounce anywhere inside SETTLE SHALL restart qualification from zero; there is no partial credit.
REQ-017 btn_out SHALL change at most once per qualification and SHALL never show a pulse shorter than STABLE_CYCLES cycles.
REQ-018 Channels SHALL be fully independent; simultaneous activity on several channels SHALL NOT affect any other channel's timing.
REQ-019 btn_out and busy SHALL be driven directly from registers (no combinational path from btn_in).

Reset
REQ-020 While rst=1 at a clock edge: both synchronizer flops, btn_out = INIT_LEVEL, busy = 0, counter = 0, FSM = STABLE for every channel.
REQ-021 rst asserted mid-SETTLE SHALL abandon qualification; btn_out stays/returns to INIT_LEVEL with no change visible after release.
REQ-022 After rst deasserts, a btn_in held at INIT_LEVEL SHALL produce no btn_out change and busy SHALL stay 0.
REQ-023 After rst deasserts with btn_in held at ~INIT_LEVEL, btn_out SHALL follow after 2+STABLE_CYCLES cycles, per REQ-015.

Verification (STABLE_CYCLES=8, WIDTH=2, INIT_LEVEL=0)
REQ-024 Clean step: ch0 0->1 at cycle 0, held -> busy[0]=1 from cycle 3, btn_out[0]=1 from cycle 10, busy[0]=0 from cycle 10; ch1 stays 0.
REQ-025 Bounce: ch0 high 5 cycles, low 1, then high -> btn_out[0] stays 0 through the glitch and rises 8 cycles after the last rising sync sample.
REQ-026 Short glitch: 1-cycle and 7-cycle high pulses -> btn_out never changes; busy pulses for 1 and 7 cycles.
REQ-027 Release: after btn_out[0]=1, btn_in[0] 1->0 held -> btn_out[0]=0 exactly 10 cycles later.
REQ-028 Independence and reset: both channels stepped on the same cycle -> both outputs rise on the same cycle; repeat with rst pulsed at cycle 6 -> outputs stay 0, busy cleared, and re-qualification takes a full 10 cycles after release.
